bp_be_issue_queue: RTL and testbench



---
 rtl/bp_be_issue_queue_if.sv | 32 +++
 rtl/bp_be_issue_queue.sv | 75 +++++++
 tb/tb_bp_be_issue_queue.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/bp_be_issue_queue_if.sv
// Handshake bundle between the FE queue producer/dispatch controller and the
// issue queue. The master drives enqueue data and the read/commit controls.
interface bp_be_issue_queue_if #(
  parameter int els_p   = 8,
  parameter int width_p = 64
);
  localparam int cnt_width_lp = $clog2(els_p + 1);

  logic [width_p-1:0]      data_i;
  logic                    v_i;
  logic                    ready_o;
  logic [width_p-1:0]      data_o;
  logic                    v_o;
  logic                    yumi_i;
  logic                    deq_i;
  logic                    roll_i;
  logic                    clr_i;
  logic                    full_o;
  logic                    empty_o;
  logic [cnt_width_lp-1:0] cnt_o;
  logic [cnt_width_lp-1:0] spec_cnt_o;

  modport master (
    output data_i, v_i, yumi_i, deq_i, roll_i, clr_i,
    input  ready_o, data_o, v_o, full_o, empty_o, cnt_o, spec_cnt_o
  );

  modport slave (
    input  data_i, v_i, yumi_i, deq_i, roll_i, clr_i,
    output ready_o, data_o, v_o, full_o, empty_o, cnt_o, spec_cnt_o
  );
endinterface

// File: rtl/bp_be_issue_queue.sv
// Circular issue queue with write, speculative-read and commit pointers.
// Reads are speculative; entries free on deq, reads rewind on roll.
module bp_be_issue_queue #(
  parameter int els_p   = 8,
  parameter int width_p = 64
) (
  input logic              clk_i,
  input logic              reset_n_i,
  bp_be_issue_queue_if.slave q
);
  localparam int idx_width_lp = $clog2(els_p);
  localparam int ptr_width_lp = $clog2(els_p) + 1;
  localparam int cnt_width_lp = $clog2(els_p + 1);

  logic [width_p-1:0]      mem [els_p];
  logic [ptr_width_lp-1:0] wptr_r, rptr_r, cptr_r;
  logic [ptr_width_lp-1:0] cptr_next;
  logic                    enq, yumi_ok, deq_ok;
  logic                    full, empty;
  logic [ptr_width_lp-1:0] occ, spec;

  // Wrap bit distinguishes full from empty when the index bits coincide.
  assign full  = (wptr_r[idx_width_lp-1:0] == cptr_r[idx_width_lp-1:0])
              && (wptr_r[ptr_width_lp-1] != cptr_r[ptr_width_lp-1]);
  assign empty = (wptr_r == cptr_r);
  assign occ   = wptr_r - cptr_r;
  assign spec  = rptr_r - cptr_r;

  assign q.ready_o    = ~full;
  assign q.full_o     = full;
  assign q.empty_o    = empty;
  assign q.v_o        = (rptr_r != wptr_r);
  assign q.data_o     = mem[rptr_r[idx_width_lp-1:0]];
  assign q.cnt_o      = cnt_width_lp'(occ);
  assign q.spec_cnt_o = cnt_width_lp'(spec);

  assign enq       = q.v_i & ~full;
  assign yumi_ok   = q.yumi_i & q.v_o;
  assign deq_ok    = q.deq_i & (spec != '0);
  assign cptr_next = cptr_r + ptr_width_lp'(deq_ok);

  // NOTE: sequential state uses <= so every pointer updates from the same
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cptr_r <= '0;
    end else if (q.clr_i) begin
      rptr_r <= wptr_r;
      cptr_r <= wptr_r;
    end else begin
      if (enq) wptr_r <= wptr_r + 1'b1;
      cptr_r <= cptr_next;
      if (q.roll_i) rptr_r <= cptr_next;
      else if (yumi_ok) rptr_r <= rptr_r + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; v_o gates any stale contents,
  // and leaving it out keeps the array mappable to plain RAM.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && !q.clr_i && enq)
      mem[wptr_r[idx_width_lp-1:0]] <= q.data_i;
  end

  a_yumi_needs_valid: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) q.yumi_i |-> q.v_o
  ) else $error("yumi_i asserted while v_o is low");

  a_deq_needs_spec: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) q.deq_i |-> (spec != '0)
  ) else $error("deq_i asserted with no read-but-uncommitted entry");

endmodule

// File: tb/tb_bp_be_issue_queue.sv
// Directed bench: status checked inline, consumed data checked by a
// scoreboard monitor that pops expected values on every accepted read.
module tb_bp_be_issue_queue;
  localparam int els_p   = 8;
  localparam int width_p = 64;

  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  bp_be_issue_queue_if #(.els_p(els_p), .width_p(width_p)) q ();

  bp_be_issue_queue #(.els_p(els_p), .width_p(width_p)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .q         (q.slave)
  );

  int tests    = 0;
  int fails    = 0;
  int consumed = 0;
  logic [width_p-1:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then return #1 after the edge with pulses cleared.
  task automatic cyc(input logic v, input logic [63:0] d, input logic y,
                     input logic dq, input logic rl, input logic cl, input logic rn);
    q.v_i = v; q.data_i = d; q.yumi_i = y; q.deq_i = dq;
    q.roll_i = rl; q.clr_i = cl; reset_n_i = rn;
    @(posedge clk_i);
    #1;
    q.v_i = 1'b0; q.yumi_i = 1'b0; q.deq_i = 1'b0;
    q.roll_i = 1'b0; q.clr_i = 1'b0; reset_n_i = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, 64'(q.ready_o), 64'd1);
    check({tag, "_v"},     64'(q.v_o),     64'd0);
    check({tag, "_empty"}, 64'(q.empty_o), 64'd1);
    check({tag, "_full"},  64'(q.full_o),  64'd0);
    check({tag, "_cnt"},   64'(q.cnt_o),   64'd0);
    check({tag, "_spec"},  64'(q.spec_cnt_o), 64'd0);
  endtask

  // Scoreboard monitor: a read is accepted when yumi_i & v_o without roll/clr.
  always @(negedge clk_i) begin
    if (reset_n_i && q.yumi_i && q.v_o && !q.roll_i && !q.clr_i) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard_extra: got %0h, expected no output", q.data_o);
      end else begin
        check("scoreboard_data", q.data_o, exp_q.pop_front());
        consumed++;
      end
    end
  end

  int   enq_idx;
  int   base;
  logic do_v, acc, y, prev_y;

  initial begin
    q.v_i = 1'b0; q.data_i = '0; q.yumi_i = 1'b0; q.deq_i = 1'b0;
    q.roll_i = 1'b0; q.clr_i = 1'b0;
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check_reset_state("reset");

    // 1: fill to full, 9th write refused
    for (int i = 0; i < 8; i++) cyc(1, 64'h10 + 64'(i), 0, 0, 0, 0, 1);
    check("fill_full",  64'(q.full_o),  64'd1);
    check("fill_ready", 64'(q.ready_o), 64'd0);
    check("fill_cnt",   64'(q.cnt_o),   64'd8);
    check("fill_data",  q.data_o,       64'h10);
    cyc(1, 64'h99, 0, 0, 0, 0, 1);
    check("ninth_cnt",  64'(q.cnt_o),   64'd8);
    check("ninth_data", q.data_o,       64'h10);

    // 2: three speculative reads, then rewind
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(64'h10 + 64'(i));
      cyc(0, 0, 1, 0, 0, 0, 1);
    end
    check("spec_data", q.data_o, 64'h13);
    check("spec_cnt",  64'(q.spec_cnt_o), 64'd3);
    cyc(0, 0, 0, 0, 1, 0, 1);
    check("roll_data", q.data_o, 64'h10);
    check("roll_spec", 64'(q.spec_cnt_o), 64'd0);
    check("roll_cnt",  64'(q.cnt_o), 64'd8);

    // 3: reread three, then deq+roll together
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(64'h10 + 64'(i));
      cyc(0, 0, 1, 0, 0, 0, 1);
    end
    cyc(0, 0, 0, 1, 1, 0, 1);
    check("deqroll_data",  q.data_o, 64'h11);
    check("deqroll_cnt",   64'(q.cnt_o), 64'd7);
    check("deqroll_spec",  64'(q.spec_cnt_o), 64'd0);
    check("deqroll_ready", 64'(q.ready_o), 64'd1);

    // 4: trim to 5 entries, then clr with a concurrent enqueue of 0xAA
    exp_q.push_back(64'h11);
    cyc(0, 0, 1, 0, 0, 0, 1);
    exp_q.push_back(64'h12);
    cyc(0, 0, 1, 1, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0, 1);
    check("trim_cnt",  64'(q.cnt_o), 64'd5);
    check("trim_data", q.data_o, 64'h13);
    cyc(1, 64'hAA, 0, 0, 0, 1, 1);
    check("clr_empty", 64'(q.empty_o), 64'd1);
    check("clr_v",     64'(q.v_o), 64'd0);
    check("clr_cnt",   64'(q.cnt_o), 64'd0);
    check("clr_spec",  64'(q.spec_cnt_o), 64'd0);

    // 5: stream 0..19 with read, and commit one cycle after each read
    base = consumed; enq_idx = 0; prev_y = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (enq_idx >= 20 && consumed - base >= 20 && !prev_y) break;
      do_v = (enq_idx < 20);
      acc  = do_v && q.ready_o;
      y    = q.v_o;
      if (acc) exp_q.push_back(64'(enq_idx));
      cyc(do_v, 64'(enq_idx), y, prev_y, 0, 0, 1);
      if (acc) enq_idx++;
      prev_y = y;
    end
    check("stream_consumed", 64'(consumed - base), 64'd20);
    check("stream_empty",    64'(q.empty_o), 64'd1);
    check("stream_cnt",      64'(q.cnt_o), 64'd0);

    // 6: reset mid-operation, then a fresh enqueue
    for (int i = 0; i < 6; i++) cyc(1, 64'h60 + 64'(i), 0, 0, 0, 0, 1);
    exp_q.push_back(64'h60);
    cyc(0, 0, 1, 0, 0, 0, 1);
    exp_q.push_back(64'h61);
    cyc(0, 0, 1, 0, 0, 0, 1);
    check("pre_rst_cnt",  64'(q.cnt_o), 64'd6);
    check("pre_rst_spec", 64'(q.spec_cnt_o), 64'd2);
    cyc(1, 64'h77, 0, 0, 0, 0, 0);
    check_reset_state("midrst");
    cyc(1, 64'h55, 0, 0, 0, 0, 1);
    check("post_rst_v",    64'(q.v_o), 64'd1);
    check("post_rst_data", q.data_o, 64'h55);
    check("post_rst_cnt",  64'(q.cnt_o), 64'd1);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
